// File: rtl/htpa_raster_scan.sv
// htpa_raster_scan
// Parametrised raster address generator for thermal-matrix frame buffers.
// Walks x across H_ACTIVE+H_BLANK counts per line and y across
// V_ACTIVE+V_BLANK lines per frame. It supports ce pacing, single-shot or
// continuous frames, a graceful stop at the frame end and an immediate abort.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   ce                  count enable; the scan advances only when ce=1
//   start, cont         start request (acted on in IDLE) and continuous mode
//   stop, abort         finish the current frame / return to idle at once
//   x, y                current pixel address
//   de, hsync, vsync    data enable and sync levels
//   busy                high while scanning
//   frame_start/done    one-cycle frame markers
//   frame_cnt           completed-frame counter, wraps modulo 2^FCNT_W
module htpa_raster_scan #(
  parameter int H_ACTIVE  = 80,
  parameter int V_ACTIVE  = 64,
  parameter int H_BLANK   = 6,
  parameter int HSYNC_OFS = 2,
  parameter int HSYNC_LEN = 1,
  parameter int V_BLANK   = 0,
  parameter int FCNT_W    = 8,
  parameter int XW        = $clog2(H_ACTIVE + H_BLANK),
  parameter int YW        = ($clog2(V_ACTIVE + V_BLANK) < 1) ? 1 : $clog2(V_ACTIVE + V_BLANK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              start,
  input  logic              cont,
  input  logic              stop,
  input  logic              abort,
  output logic [XW-1:0]     x,
  output logic [YW-1:0]     y,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              busy,
  output logic              frame_start,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE + H_BLANK - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE + V_BLANK - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic                cont_q, cont_d;
  logic                stop_q, stop_d;
  logic [FCNT_W-1:0]   cnt_q, cnt_d;
  logic                fs_q, fs_d;
  logic                fd_q, fd_d;
  logic                busy_q, busy_d;
  logic                de_q, de_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic                stop_seen;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cont_d    = cont_q;
    stop_d    = stop_q;
    cnt_d     = cnt_q;
    fs_d      = 1'b0;
    fd_d      = 1'b0;
    // A stop arriving on the final-count edge still ends continuous mode.
    stop_seen = stop_q | stop;

    case (state_q)
      IDLE: begin
        // Abort outranks start even while idle.
        if (start && !abort) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
          cont_d  = cont;
          stop_d  = 1'b0;
          fs_d    = 1'b1;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
          cont_d  = 1'b0;
          stop_d  = 1'b0;
        end else begin
          stop_d = stop_seen;
          if (ce) begin
            if (x_q == X_LAST) begin
              x_d = '0;
              if (y_q == Y_LAST) begin
                y_d   = '0;
                fd_d  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cont_q && !stop_seen) begin
                  fs_d = 1'b1;
                end else begin
                  state_d = IDLE;
                  cont_d  = 1'b0;
                  stop_d  = 1'b0;
                end
              end else begin
                y_d = y_q + 1'b1;
              end
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Levels are derived from the next position so they line up with x/y.
    busy_d = (state_d == SCAN);
    de_d   = busy_d && (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
    hs_d   = busy_d && (int'(x_d) >= H_ACTIVE + HSYNC_OFS) &&
             (int'(x_d) < H_ACTIVE + HSYNC_OFS + HSYNC_LEN);
    vs_d   = busy_d && (int'(y_d) >= V_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      cnt_q   <= cnt_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign busy        = busy_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_htpa_raster_scan.sv
// tb_htpa_raster_scan
// Drives two scanners: instance 0 uses the default 80x64 geometry and
// instance 1 uses a 4x3 active area with blanking and a 2-bit frame counter.
// A frame-position model predicts every output on every cycle.
module tb_htpa_raster_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [2];
  logic ce    [2];
  logic start [2];
  logic cont  [2];
  logic stop  [2];
  logic abort [2];

  logic [6:0] x0;
  logic [5:0] y0;
  logic [7:0] fc0;
  logic       de0, hs0, vs0, bz0, fs0, fd0;
  logic [2:0] x1, y1;
  logic [1:0] fc1;
  logic       de1, hs1, vs1, bz1, fs1, fd1;

  htpa_raster_scan dut0 (
    .clk(clk), .rst_n(rst_n[0]), .ce(ce[0]), .start(start[0]), .cont(cont[0]),
    .stop(stop[0]), .abort(abort[0]), .x(x0), .y(y0), .de(de0), .hsync(hs0),
    .vsync(vs0), .busy(bz0), .frame_start(fs0), .frame_done(fd0), .frame_cnt(fc0)
  );

  htpa_raster_scan #(
    .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .HSYNC_OFS(0), .HSYNC_LEN(2),
    .V_BLANK(2), .FCNT_W(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .ce(ce[1]), .start(start[1]), .cont(cont[1]),
    .stop(stop[1]), .abort(abort[1]), .x(x1), .y(y1), .de(de1), .hsync(hs1),
    .vsync(vs1), .busy(bz1), .frame_start(fs1), .frame_done(fd1), .frame_cnt(fc1)
  );

  integer ox [2], oy [2], ofc [2];
  logic   ode [2], ohs [2], ovs [2], obz [2], ofs [2], ofd [2];

  assign ox[0]  = {25'b0, x0};
  assign oy[0]  = {26'b0, y0};
  assign ofc[0] = {24'b0, fc0};
  assign ox[1]  = {29'b0, x1};
  assign oy[1]  = {29'b0, y1};
  assign ofc[1] = {30'b0, fc1};
  assign ode[0] = de0;  assign ode[1] = de1;
  assign ohs[0] = hs0;  assign ohs[1] = hs1;
  assign ovs[0] = vs0;  assign ovs[1] = vs1;
  assign obz[0] = bz0;  assign obz[1] = bz1;
  assign ofs[0] = fs0;  assign ofs[1] = fs1;
  assign ofd[0] = fd0;  assign ofd[1] = fd1;

  int p_ha [2] = '{80, 4};
  int p_hb [2] = '{6, 2};
  int p_va [2] = '{64, 3};
  int p_vb [2] = '{0, 2};
  int p_ho [2] = '{2, 0};
  int p_hl [2] = '{1, 2};
  int p_fw [2] = '{8, 2};

  // Model state: a linear position inside the frame plus the control flags.
  bit m_busy [2];
  int m_p    [2];
  bit m_cont [2];
  bit m_stop [2];
  bit m_fs   [2];
  bit m_fd   [2];
  int m_cnt  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int total_cnt;
      bit seen;
      total_cnt = (p_ha[i] + p_hb[i]) * (p_va[i] + p_vb[i]);
      m_fs[i] = 1'b0;
      m_fd[i] = 1'b0;
      if (!rst_n[i]) begin
        m_busy[i] = 1'b0; m_p[i] = 0; m_cont[i] = 1'b0; m_stop[i] = 1'b0; m_cnt[i] = 0;
      end else if (!m_busy[i]) begin
        if (start[i] && !abort[i]) begin
          m_busy[i] = 1'b1; m_p[i] = 0; m_cont[i] = cont[i]; m_stop[i] = 1'b0; m_fs[i] = 1'b1;
        end
      end else if (abort[i]) begin
        m_busy[i] = 1'b0; m_p[i] = 0; m_cont[i] = 1'b0; m_stop[i] = 1'b0;
      end else begin
        seen = m_stop[i] || stop[i];
        if (ce[i]) begin
          if (m_p[i] == total_cnt - 1) begin
            m_p[i]   = 0;
            m_fd[i]  = 1'b1;
            m_cnt[i] = (m_cnt[i] + 1) % (1 << p_fw[i]);
            if (m_cont[i] && !seen) m_fs[i] = 1'b1;
            else begin
              m_busy[i] = 1'b0; m_cont[i] = 1'b0; seen = 1'b0;
            end
          end else begin
            m_p[i] = m_p[i] + 1;
          end
        end
        m_stop[i] = seen;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int st_de [2], st_hs [2], st_vs [2];

  task automatic check_output(input string name, input integer act, input integer exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      int ht, ex, ey;
      bit ede, ehs, evs;
      ht  = p_ha[i] + p_hb[i];
      ex  = m_p[i] % ht;
      ey  = m_p[i] / ht;
      ede = m_busy[i] && ex < p_ha[i] && ey < p_va[i];
      ehs = m_busy[i] && ex >= p_ha[i] + p_ho[i] && ex < p_ha[i] + p_ho[i] + p_hl[i];
      evs = m_busy[i] && ey >= p_va[i];
      total++;
      if (ox[i] !== ex || oy[i] !== ey || ode[i] !== ede || ohs[i] !== ehs ||
          ovs[i] !== evs || obz[i] !== m_busy[i] || ofs[i] !== m_fs[i] ||
          ofd[i] !== m_fd[i] || ofc[i] !== m_cnt[i]) begin
        bad++;
        $display("[TB] FAIL model_cmp[%0d] t=%0t got x=%0d y=%0d de=%b hs=%b vs=%b busy=%b fs=%b fd=%b cnt=%0d expected x=%0d y=%0d de=%b hs=%b vs=%b busy=%b fs=%b fd=%b cnt=%0d",
                 i, $time, ox[i], oy[i], ode[i], ohs[i], ovs[i], obz[i], ofs[i], ofd[i], ofc[i],
                 ex, ey, ede, ehs, evs, m_busy[i], m_fs[i], m_fd[i], m_cnt[i]);
      end
    end
  endtask

  // Every time step of the stimulus goes through here, so the model compare
  // runs on each cycle and the level statistics are accumulated.
  task automatic tick();
    @(negedge clk);
    if (chk_en) check_model();
    for (int i = 0; i < 2; i++) begin
      if (ode[i] === 1'b1) st_de[i]++;
      if (ohs[i] === 1'b1) st_hs[i]++;
      if (ovs[i] === 1'b1) st_vs[i]++;
    end
  endtask

  task automatic clear_stats(input int i);
    st_de[i] = 0; st_hs[i] = 0; st_vs[i] = 0;
  endtask

  task automatic pulse_start(input int i, input bit c);
    start[i] = 1'b1; cont[i] = c;
    tick();
    start[i] = 1'b0; cont[i] = 1'b0;
  endtask

  // Runs until frame_done, optionally toggling ce 1,0,1,0; bounded by budget.
  task automatic apply_stimulus(input int i, input bit toggle, input int budget,
                                output int n, output int nce);
    bit got;
    got = 1'b0; n = 0; nce = 0;
    while (!got && n < budget) begin
      if (toggle) ce[i] = (n % 2 == 0);
      if (ce[i]) nce++;
      tick();
      n++;
      if (ofd[i] === 1'b1) got = 1'b1;
    end
    ce[i] = 1'b1;
    if (!got) check_output("frame_done_timeout", n, -1);
  endtask

  initial begin
    int n, nce, k;
    int seq_exp [5];
    seq_exp = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; ce[i] = 1'b1; start[i] = 1'b0; cont[i] = 1'b0;
      stop[i] = 1'b0; abort[i] = 1'b0;
    end
    repeat (3) tick();
    chk_en = 1'b1;
    check_output("reset_busy", obz[0], 0);
    check_output("reset_cnt", ofc[0], 0);
    check_output("reset_x", ox[1], 0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Single-shot default frame.
    clear_stats(0);
    pulse_start(0, 1'b0);
    check_output("start_de", ode[0], 1);
    check_output("start_fs", ofs[0], 1);
    apply_stimulus(0, 1'b0, 6000, n, nce);
    check_output("single_len", n, 5504);
    check_output("single_cnt", ofc[0], 1);
    check_output("single_busy", obz[0], 0);
    check_output("single_de_cycles", st_de[0], 5120);
    check_output("single_hs_cycles", st_hs[0], 64);
    check_output("single_vs_cycles", st_vs[0], 0);

    // Continuous, stop during the third frame.
    rst_n[0] = 1'b0; tick(); rst_n[0] = 1'b1;
    pulse_start(0, 1'b1);
    apply_stimulus(0, 1'b0, 6000, n, nce);
    check_output("cont_f1_fs", ofs[0], 1);
    check_output("cont_f1_cnt", ofc[0], 1);
    apply_stimulus(0, 1'b0, 6000, n, nce);
    check_output("cont_f2_fs", ofs[0], 1);
    repeat (100) tick();
    stop[0] = 1'b1; tick(); stop[0] = 1'b0;
    apply_stimulus(0, 1'b0, 6000, n, nce);
    check_output("cont_f3_cnt", ofc[0], 3);
    check_output("cont_f3_busy", obz[0], 0);
    repeat (5) tick();

    // Start without ce, then ce toggling.
    ce[0] = 1'b0;
    pulse_start(0, 1'b0);
    check_output("start_no_ce_busy", obz[0], 1);
    apply_stimulus(0, 1'b1, 12000, n, nce);
    check_output("toggle_ce_len", nce, 5504);
    check_output("toggle_cnt", ofc[0], 4);

    // Abort at x=10, y=5.
    pulse_start(0, 1'b0);
    k = 0;
    while (!(ox[0] == 10 && oy[0] == 5) && k < 2000) begin tick(); k++; end
    check_output("abort_pos_reached", k < 2000, 1);
    abort[0] = 1'b1; tick(); abort[0] = 1'b0;
    check_output("abort_busy", obz[0], 0);
    check_output("abort_y", oy[0], 0);
    check_output("abort_cnt", ofc[0], 4);
    repeat (3) tick();

    // Start and abort together while idle.
    start[0] = 1'b1; abort[0] = 1'b1; tick(); start[0] = 1'b0; abort[0] = 1'b0;
    check_output("idle_abort_busy", obz[0], 0);

    // Reset mid-frame.
    pulse_start(0, 1'b0);
    repeat (50) tick();
    rst_n[0] = 1'b0; tick(); rst_n[0] = 1'b1;
    check_output("midreset_cnt", ofc[0], 0);
    check_output("midreset_x", ox[0], 0);

    // Small geometry: continuous five frames with a 2-bit counter.
    stop[1] = 1'b1; tick(); stop[1] = 1'b0;
    pulse_start(1, 1'b1);
    for (int f = 0; f < 5; f++) begin
      if (f == 2) begin
        repeat (7) tick();
        start[1] = 1'b1; tick(); start[1] = 1'b0;
      end
      if (f == 4) begin
        repeat (3) tick();
        stop[1] = 1'b1; tick(); stop[1] = 1'b0;
      end
      apply_stimulus(1, 1'b0, 100, n, nce);
      check_output($sformatf("wrap_cnt_f%0d", f + 1), ofc[1], seq_exp[f]);
    end
    check_output("wrap_end_busy", obz[1], 0);

    // Small geometry single frame level statistics.
    clear_stats(1);
    pulse_start(1, 1'b0);
    apply_stimulus(1, 1'b0, 100, n, nce);
    check_output("small_len", n, 30);
    check_output("small_de_cycles", st_de[1], 12);
    check_output("small_hs_cycles", st_hs[1], 10);
    check_output("small_vs_cycles", st_vs[1], 12);
    check_output("small_cnt", ofc[1], 2);

    // Abort on the final count.
    pulse_start(1, 1'b0);
    k = 0;
    while (!(ox[1] == 5 && oy[1] == 4) && k < 100) begin tick(); k++; end
    check_output("final_pos_reached", k < 100, 1);
    abort[1] = 1'b1; tick(); abort[1] = 1'b0;
    check_output("final_abort_fd", ofd[1], 0);
    check_output("final_abort_cnt", ofc[1], 2);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
